// File: rtl/cs_clip_queue_if.sv
// Handshake bundle between the texel stage, the clip queue and the raster stage.
// The slave view is the clip queue itself: it consumes triangles from the texel
// side and presents queued triangles to the raster side. The master view is the
// surrounding environment that drives the texel side and pops the raster side.
interface cs_clip_queue_if #(
   parameter int DATA_W     = 96,
   parameter int NUM_PLANES = 6
);
   // texel stage -> clip queue
   logic                  texel_ready;
   logic [DATA_W-1:0]     texel_data;
   logic [NUM_PLANES-1:0] texel_clip;
   logic                  texel_read;

   // clip queue -> triangle (raster) stage
   logic                  triangle_ready;
   logic [DATA_W-1:0]     triangle_data;
   logic                  triangle_read;

   modport slave (
      input  texel_ready,
      input  texel_data,
      input  texel_clip,
      output texel_read,
      output triangle_ready,
      output triangle_data,
      input  triangle_read
   );

   modport master (
      output texel_ready,
      output texel_data,
      output texel_clip,
      input  texel_read,
      input  triangle_ready,
      input  triangle_data,
      output triangle_read
   );
endinterface

// File: rtl/cs_clip_queue.sv
// Clip-and-queue stage between the texel and raster stages.
// Triangles wholly outside any enabled clip plane are consumed and discarded;
// survivors are stored in a DEPTH-entry FIFO whose head is presented
// combinationally to the raster stage. Saturating pass/drop counters track
// how many triangles went each way since reset or the last stats_clear.
module cs_clip_queue #(
   parameter int DATA_W     = 96,
   parameter int DEPTH      = 4,
   parameter int NUM_PLANES = 6,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PLANES-1:0]    i_clip_enable,
   input  logic                     i_clip_bypass,
   input  logic                     i_stats_clear,
   cs_clip_queue_if.slave           bus_s,
   output logic [$clog2(DEPTH):0]   o_occupancy,
   output logic [CNT_W-1:0]         o_pass_count,
   output logic [CNT_W-1:0]         o_drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [OCC_W-1:0]  r_occ;

   // per-cycle decisions
   logic              w_hit;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_drop_evt;

   // increment requests for the two statistics counters: bit 0 pass, bit 1 drop
   logic [1:0]             w_cnt_inc;
   logic [2*CNT_W-1:0]     w_cnt_flat;

   // Clip decision uses the mode inputs of the current cycle only, so a mode
   // change affects triangles accepted from this cycle on; queued entries keep
   // whatever decision was made when they were accepted.
   assign w_hit   = |(bus_s.texel_clip & i_clip_enable);
   assign w_drop  = !i_clip_bypass && w_hit;

   assign w_full  = (r_occ == OCC_FULL);
   assign w_empty = (r_occ == '0);

   // A drop never needs FIFO space, so it is consumed even when full. A
   // surviving triangle waits for space as seen at the start of the cycle;
   // a pop in the same cycle does not help, which keeps triangle_read off the
   // combinational path to texel_read. texel_read is forced low during reset.
   assign w_accept   = !rst && bus_s.texel_ready && (w_drop || !w_full);
   assign w_push     = w_accept && !w_drop;
   assign w_drop_evt = w_accept && w_drop;
   assign w_pop      = bus_s.triangle_read && !w_empty;

   assign bus_s.texel_read     = w_accept;
   assign bus_s.triangle_ready = !w_empty;
   assign bus_s.triangle_data  = r_mem[r_rd_ptr];
   assign o_occupancy          = r_occ;

   // Payload write at the write pointer; storage needs no reset because
   // triangle_ready masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus_s.texel_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
   // is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_occ <= r_occ + 1'b1;
         end else if (w_pop && !w_push) begin
            r_occ <= r_occ - 1'b1;
         end
      end
   end

   assign w_cnt_inc = {w_drop_evt, w_push};

   // Two identical saturating counters; clear wins over a same-cycle event.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;

         // Count events, holding at all-ones instead of wrapping.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt <= '0;
            end else if (i_stats_clear) begin
               r_cnt <= '0;
            end else if (w_cnt_inc[gi] && (r_cnt != '1)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_cnt_flat[gi*CNT_W +: CNT_W] = r_cnt;
      end
   endgenerate

   assign o_pass_count = w_cnt_flat[0 +: CNT_W];
   assign o_drop_count = w_cnt_flat[CNT_W +: CNT_W];

endmodule

// File: tb/tb_cs_clip_queue.sv
// Bench for cs_clip_queue: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_cs_clip_queue;
   localparam int DATA_W     = 96;
   localparam int DEPTH      = 4;
   localparam int NUM_PLANES = 6;
   localparam int CNT_W      = 4;
   localparam int OCC_W      = $clog2(DEPTH) + 1;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_PLANES-1:0] clip_enable = '0;
   logic                  clip_bypass = 1'b0;
   logic                  stats_clear = 1'b0;
   logic [OCC_W-1:0]      occupancy;
   logic [CNT_W-1:0]      pass_count;
   logic [CNT_W-1:0]      drop_count;

   cs_clip_queue_if #(.DATA_W(DATA_W), .NUM_PLANES(NUM_PLANES)) bus ();

   cs_clip_queue #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .NUM_PLANES (NUM_PLANES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_clip_enable (clip_enable),
      .i_clip_bypass (clip_bypass),
      .i_stats_clear (stats_clear),
      .bus_s         (bus),
      .o_occupancy   (occupancy),
      .o_pass_count  (pass_count),
      .o_drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [DATA_W-1:0] model_q [$];
   int model_pass = 0;
   int model_drop = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   // One clock of traffic: apply inputs, compare the DUT against the model,
   // then advance the model by the edge that consumes these inputs.
   task automatic cycle(input logic tr, input logic [DATA_W-1:0] d,
                        input logic [NUM_PLANES-1:0] clip, input logic [NUM_PLANES-1:0] en,
                        input logic byp, input logic trd, input logic clr);
      bit is_drop, exp_read, push, pop;
      @(posedge clk);
      #1;
      bus.texel_ready   = tr;
      bus.texel_data    = d;
      bus.texel_clip    = clip;
      bus.triangle_read = trd;
      clip_enable       = en;
      clip_bypass       = byp;
      stats_clear       = clr;
      #1;
      is_drop  = !byp && ((clip & en) != '0);
      exp_read = tr && (is_drop || (model_q.size() < DEPTH));
      push     = exp_read && !is_drop;
      pop      = trd && (model_q.size() != 0);

      chk("texel_read",     DATA_W'(bus.texel_read),     DATA_W'(exp_read));
      chk("triangle_ready", DATA_W'(bus.triangle_ready), DATA_W'(model_q.size() != 0));
      chk("occupancy",      DATA_W'(occupancy),          DATA_W'(model_q.size()));
      chk("pass_count",     DATA_W'(pass_count),         DATA_W'(model_pass));
      chk("drop_count",     DATA_W'(drop_count),         DATA_W'(model_drop));
      if (model_q.size() != 0) chk("triangle_data", bus.triangle_data, model_q[0]);

      if (exp_read || pop)
         $display("t=%0t in=%0d drop=%0d pop=%0d data=%0h occ=%0d",
                  $time, exp_read, is_drop, pop, d, model_q.size());

      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(d);
      if (clr) begin
         model_pass = 0;
         model_drop = 0;
      end else begin
         if (push && model_pass < CNT_MAX) model_pass++;
         if (exp_read && is_drop && model_drop < CNT_MAX) model_drop++;
      end
   endtask

   initial begin
      bus.texel_ready   = 1'b0;
      bus.texel_data    = '0;
      bus.texel_clip    = '0;
      bus.triangle_read = 1'b0;

      // reset values
      #3;
      chk("rst_occupancy", DATA_W'(occupancy), '0);
      chk("rst_triangle_ready", DATA_W'(bus.triangle_ready), '0);
      chk("rst_pass", DATA_W'(pass_count), '0);
      chk("rst_drop", DATA_W'(drop_count), '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // three plain triangles, no pops
      cycle(1, 96'hA, '0, '0, 0, 0, 0);
      cycle(1, 96'hB, '0, '0, 0, 0, 0);
      cycle(1, 96'hC, '0, '0, 0, 0, 0);
      // fill to DEPTH
      cycle(1, 96'hD, '0, '0, 0, 0, 0);
      // full: survivor held off while the head is popped
      cycle(1, 96'hE, '0, '0, 0, 1, 0);
      cycle(1, 96'hE, '0, '0, 0, 0, 0);
      // full: a clipped triangle is still consumed
      cycle(1, 96'hF0, 6'b000001, 6'b000001, 0, 0, 0);
      // make room, then offer non-clipped and bypassed triangles
      cycle(0, '0, '0, '0, 0, 1, 0);
      cycle(0, '0, '0, '0, 0, 1, 0);
      cycle(1, 96'h11, 6'b000010, 6'b000001, 0, 0, 0);
      cycle(1, 96'h12, 6'b000010, 6'b111111, 1, 0, 0);
      // drain across the pointer wrap
      for (int i = 0; i < 6; i++) cycle(0, '0, '0, '0, 0, 1, 0);

      // drop counter saturation, then clear in the same cycle as a drop
      for (int i = 0; i < 17; i++) cycle(1, rand_data(), 6'b000001, 6'b000001, 0, 0, 0);
      cycle(1, rand_data(), 6'b000001, 6'b000001, 0, 0, 1);
      cycle(0, '0, '0, '0, 0, 0, 0);

      // random traffic in phases of varying pop pressure
      for (int i = 0; i < 600; i++) begin
         logic [NUM_PLANES-1:0] clip;
         logic trd;
         clip = ($urandom_range(0, 2) == 0) ? NUM_PLANES'($urandom()) : '0;
         if (i < 200)      trd = ($urandom_range(0, 3) == 0);
         else if (i < 400) trd = ($urandom_range(0, 3) != 0);
         else              trd = 1'b1;
         cycle($urandom_range(0, 3) != 0, rand_data(), clip, NUM_PLANES'($urandom()),
               $urandom_range(0, 7) == 0, trd, $urandom_range(0, 40) == 0);
      end

      // asynchronous reset with two entries queued
      for (int i = 0; i < 6; i++) cycle(0, '0, '0, '0, 0, 1, 0);
      cycle(1, 96'h21, '0, '0, 0, 0, 0);
      cycle(1, 96'h22, '0, '0, 0, 0, 0);
      @(posedge clk);
      #3;
      bus.texel_ready   = 1'b1;
      bus.texel_clip    = '0;
      bus.triangle_read = 1'b0;
      stats_clear       = 1'b0;
      rst               = 1'b1;
      #1;
      chk("arst_triangle_ready", DATA_W'(bus.triangle_ready), '0);
      chk("arst_occupancy", DATA_W'(occupancy), '0);
      chk("arst_pass", DATA_W'(pass_count), '0);
      chk("arst_drop", DATA_W'(drop_count), '0);
      chk("arst_texel_read", DATA_W'(bus.texel_read), '0);
      model_q.delete();
      model_pass = 0;
      model_drop = 0;
      bus.texel_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(0, '0, '0, '0, 0, 1, 0);
      cycle(0, '0, '0, '0, 0, 0, 0);
      cycle(1, 96'h31, '0, '0, 0, 0, 0);
      cycle(0, '0, '0, '0, 0, 1, 0);
      cycle(0, '0, '0, '0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // safety net against a hung run
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cs_clip_queue.md
# cs_clip_queue

Buffered, parametrised clip-and-split controller between the texel stage and the triangle (raster) stage. Each triangle offered by the texel stage arrives with per-plane outside flags. The block discards triangles that lie outside any enabled clip plane and stores the survivors in a DEPTH-entry FIFO for the downstream stage. It keeps saturating pass/drop statistics, and a bypass mode disables clipping.

## Interface

Parameters:
- DATA_W, 96, width of one triangle payload.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- NUM_PLANES, 6, number of clip planes and flag bits.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- clip_enable  in  NUM_PLANES  per-plane enable mask; bit i enables plane i.
- clip_bypass  in  1  1 = never drop; every triangle is queued.
- texel_ready  in  1  upstream has a valid triangle on texel_data/texel_clip.
- texel_data  in  DATA_W  triangle payload.
- texel_clip  in  NUM_PLANES  bit i = triangle entirely outside plane i.
- texel_read  out  1  triangle consumed from upstream this cycle (queued or dropped).
- triangle_ready  out  1  FIFO non-empty; triangle_data valid.
- triangle_data  out  DATA_W  FIFO head entry.
- triangle_read  in  1  downstream pops the head this cycle.
- occupancy  out  $clog2(DEPTH)+1  number of valid FIFO entries.
- pass_count  out  CNT_W  triangles queued since reset/clear.
- drop_count  out  CNT_W  triangles dropped since reset/clear.
- stats_clear  in  1  synchronous clear of both counters.

## Operation

Drop condition (combinational): drop = !clip_bypass && |(texel_clip & clip_enable).

Accept rule:
- texel_read = texel_ready && (drop || !full).
- full = (occupancy == DEPTH).
- A dropped triangle is consumed even when the FIFO is full.
- A non-dropped triangle is held off (texel_read = 0) while full, even if triangle_read = 1 in the same cycle. This means there is no combinational path from triangle_read to texel_read.

Queueing and popping:
- push = texel_read && !drop; texel_data is written at the write pointer.
- pop = triangle_read && triangle_ready. If triangle_ready = 0, triangle_read is ignored and no state changes.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy update per cycle:
  - push && !pop: +1.
  - pop && !push: −1.
  - push && pop: unchanged; both pointers advance.
- Outputs derived from the FIFO:
  - triangle_ready = (occupancy != 0).
  - triangle_data = mem[rd_ptr], read combinationally from storage.

Statistics counters:
- pass_count increments on each push; drop_count increments on each texel_read && drop.
- Both saturate at 2^CNT_W − 1 (no wrap).
- stats_clear has priority: both counters go to 0 in that cycle and that cycle's events are not counted.

Sampling and modes:
- clip_enable and clip_bypass are sampled only in the accept cycle, so a mode change affects only triangles accepted from that cycle on.
- Queued entries are never re-evaluated.

## Timing

Reset values (rst = 1, asynchronous):
- Pointers, occupancy, pass_count, drop_count = 0.
- triangle_ready = 0.
- texel_read = 0 while rst is high. Its gating is combinational, so with texel_ready = 0 it is 0 regardless.
- triangle_data is don't-care while triangle_ready = 0.
- Reset mid-operation discards all queued entries; no partial state survives.

Latency and throughput:
- A triangle pushed in cycle N appears on triangle_ready/triangle_data in cycle N+1. The FIFO has no same-cycle bypass.
- A drop completes in one cycle. texel_read pulses in cycle N; drop_count updates at the end of cycle N.
- Sustained throughput is one triangle per cycle when the downstream pops every cycle and occupancy < DEPTH.

Boundary cases:
- Full, with a non-dropped triangle and a pop in the same cycle: texel_read = 0. The pop completes; the triangle is accepted the next cycle.
- Empty, with a push only: occupancy 0→1; triangle_ready rises next cycle.
- Pointer wrap from DEPTH−1 to 0 keeps FIFO order intact.
- Counters at saturation stay at all-ones until stats_clear or rst.

## Test plan

1. Reset, then offer 3 triangles (payloads 0xA, 0xB, 0xC) with texel_clip = 0 and triangle_read = 0 → texel_read high for 3 cycles; occupancy 1, 2, 3; pass_count = 3; triangle_data = 0xA.
2. Fill to DEPTH = 4, then offer a non-clipped triangle with triangle_read = 1 → texel_read = 0 that cycle; occupancy 4→3; the triangle is accepted next cycle with occupancy returning to 4. Output order is preserved across pointer wrap.
3. FIFO full, clip_enable = 6'b000001, offer texel_clip = 6'b000001 → texel_read = 1 the same cycle; drop_count +1; occupancy unchanged at 4.
4. texel_clip = 6'b000010 with clip_enable = 6'b000001, then with clip_bypass = 1 and clip_enable = 6'b111111 → both triangles queued; drop_count unchanged.
5. CNT_W = 4: drop 17 triangles → drop_count stops at 15. Then assert stats_clear in the same cycle as another drop → drop_count = 0 next cycle.
6. With 2 entries queued, assert rst mid-stream → triangle_ready and occupancy are 0 immediately (asynchronous); counters are 0; triangle_read issued after reset causes no change.
